// File: rtl/keypad_scanner_pkg.sv
// Shared constants and helpers for the 4x4 keypad scanner.
// Column and row lines are active-low throughout.
package keypad_scanner_pkg;

   localparam logic [3:0] KEYPAD_COL_RESET   = 4'b1110;
   localparam logic [3:0] KEYPAD_NO_ROW      = 4'hF;

   localparam logic [1:0] KEYPAD_ST_SCAN     = 2'd0;
   localparam logic [1:0] KEYPAD_ST_DEBOUNCE = 2'd1;
   localparam logic [1:0] KEYPAD_ST_HELD     = 2'd2;

   function automatic logic [3:0] rotate_col(input logic [3:0] col);
      return {col[2:0], col[3]};
   endfunction

   // Priority pick: the lowest-numbered row that reads low wins.
   function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
      logic [1:0] idx;
      if (!rows[0]) begin
         idx = 2'd0;
      end else if (!rows[1]) begin
         idx = 2'd1;
      end else if (!rows[2]) begin
         idx = 2'd2;
      end else begin
         idx = 2'd3;
      end
      return idx;
   endfunction

   function automatic logic [1:0] col_index(input logic [3:0] col);
      logic [1:0] idx;
      case (col)
         4'b1110: idx = 2'd0;
         4'b1101: idx = 2'd1;
         4'b1011: idx = 2'd2;
         4'b0111: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Two-flop synchronizer for asynchronous board inputs; resets to all-ones
// so that idle pulled-up lines read as inactive.
module sync2 #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   // Two-stage capture of the asynchronous input.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta <= '1;
         q    <= '1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: rotates active-low column drive, debounces one key at a
// time and reports it as {row, col} with a single-cycle valid strobe.
module keypad_scanner
   import keypad_scanner_pkg::*;
#(
   parameter int SCAN_LIMIT     = 49999,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row_n,
   output logic [3:0] col_sel,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam int            DW        = (SCAN_LIMIT > 0) ? $clog2(SCAN_LIMIT + 1) : 1;
   localparam logic [DW-1:0] DWELL_MAX = DW'(SCAN_LIMIT);
   localparam logic [3:0]    DEB_MAX   = 4'(DEBOUNCE_SCANS);

   logic [3:0]    row_s;
   logic [DW-1:0] dwell;
   logic          sample;

   logic [1:0] state, state_nxt;
   logic [1:0] cand_row, cand_row_nxt;
   logic [1:0] cand_col, cand_col_nxt;
   logic [3:0] stable, stable_nxt, stable_inc;
   logic [3:0] rel, rel_nxt, rel_inc;
   logic [3:0] col_nxt, code_nxt;
   logic       valid_nxt, held_nxt;

   sync2 #(.WIDTH(4)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (row_n),
      .q   (row_s)
   );

   assign sample = (dwell == DWELL_MAX);

   // Dwell timer: one full period per column, rows read on its last cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dwell <= '0;
      end else if (sample) begin
         dwell <= '0;
      end else begin
         dwell <= dwell + DW'(1);
      end
   end

   // Next-state and output decode, evaluated only at sample points.
   always_comb begin
      state_nxt    = state;
      col_nxt      = col_sel;
      cand_row_nxt = cand_row;
      cand_col_nxt = cand_col;
      stable_nxt   = stable;
      rel_nxt      = rel;
      code_nxt     = key_code;
      valid_nxt    = 1'b0;
      held_nxt     = key_held;
      stable_inc   = (stable >= DEB_MAX) ? DEB_MAX : stable + 4'd1;
      rel_inc      = (rel >= DEB_MAX) ? DEB_MAX : rel + 4'd1;

      if (sample) begin
         case (state)
            KEYPAD_ST_SCAN: begin
               if (row_s == KEYPAD_NO_ROW) begin
                  col_nxt = rotate_col(col_sel);
               end else begin
                  cand_row_nxt = lowest_low_row(row_s);
                  cand_col_nxt = col_index(col_sel);
                  stable_nxt   = 4'd1;
                  rel_nxt      = 4'd0;
                  if (DEB_MAX == 4'd1) begin
                     code_nxt  = {lowest_low_row(row_s), col_index(col_sel)};
                     valid_nxt = 1'b1;
                     held_nxt  = 1'b1;
                     state_nxt = KEYPAD_ST_HELD;
                  end else begin
                     state_nxt = KEYPAD_ST_DEBOUNCE;
                  end
               end
            end
            KEYPAD_ST_DEBOUNCE: begin
               if (!row_s[cand_row]) begin
                  stable_nxt = stable_inc;
                  if (stable_inc == DEB_MAX) begin
                     code_nxt  = {cand_row, cand_col};
                     valid_nxt = 1'b1;
                     held_nxt  = 1'b1;
                     rel_nxt   = 4'd0;
                     state_nxt = KEYPAD_ST_HELD;
                  end else begin
                     state_nxt = KEYPAD_ST_DEBOUNCE;
                  end
               end else begin
                  // Bounce or short tap: drop it silently and move on.
                  stable_nxt = 4'd0;
                  col_nxt    = rotate_col(col_sel);
                  state_nxt  = KEYPAD_ST_SCAN;
               end
            end
            KEYPAD_ST_HELD: begin
               if (row_s[cand_row]) begin
                  rel_nxt = rel_inc;
                  if (rel_inc == DEB_MAX) begin
                     held_nxt   = 1'b0;
                     rel_nxt    = 4'd0;
                     stable_nxt = 4'd0;
                     col_nxt    = rotate_col(col_sel);
                     state_nxt  = KEYPAD_ST_SCAN;
                  end else begin
                     state_nxt = KEYPAD_ST_HELD;
                  end
               end else begin
                  rel_nxt = 4'd0;
               end
            end
            default: begin
               held_nxt   = 1'b0;
               stable_nxt = 4'd0;
               rel_nxt    = 4'd0;
               col_nxt    = KEYPAD_COL_RESET;
               state_nxt  = KEYPAD_ST_SCAN;
            end
         endcase
      end else begin
         state_nxt = state;
      end
   end

   // FSM state and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= KEYPAD_ST_SCAN;
         col_sel   <= KEYPAD_COL_RESET;
         cand_row  <= 2'd0;
         cand_col  <= 2'd0;
         stable    <= 4'd0;
         rel       <= 4'd0;
         key_code  <= 4'd0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
      end else begin
         state     <= state_nxt;
         col_sel   <= col_nxt;
         cand_row  <= cand_row_nxt;
         cand_col  <= cand_col_nxt;
         stable    <= stable_nxt;
         rel       <= rel_nxt;
         key_code  <= code_nxt;
         key_valid <= valid_nxt;
         key_held  <= held_nxt;
      end
   end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 push-button matrix and reports one debounced key press at a time as a 4-bit key code with a single-cycle valid strobe. It is the input-side counterpart of the multiplexed 7-segment display driver. It drives active-low one-hot column selects in the same rotating fashion as the display digit selects, and it reads back active-low rows. It sits between the board keypad pins and the time-setting logic.

## Interface
- `SCAN_LIMIT`, default 49999: dwell per column is SCAN_LIMIT+1 clk cycles.
- `DEBOUNCE_SCANS`, default 4: number of consecutive equal samples needed to accept a press or a release (range 1..15).
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `row_n`  in  4  matrix rows; active-low, externally pulled up, asynchronous to clk.
- `col_sel`  out  4  column drive; active-low one-hot.
- `key_code`  out  4  code of the last accepted key, {row[1:0], col[1:0]} (row*4+col).
- `key_valid`  out  1  one-cycle strobe when a new press is accepted.
- `key_held`  out  1  high while the accepted key remains pressed.

## Operation
- `row_n` passes through a 2-flop synchronizer, giving `row_s`. All decisions use `row_s`.
- Dwell counter `dwell` runs 0..SCAN_LIMIT and wraps. A "sample point" is the cycle where `dwell == SCAN_LIMIT`.
- Rows are sampled only at sample points. This leaves a full dwell for line settling after a column change.
- FSM states:
  - **SCAN**
    - At a sample point with `row_s == 4'hF`: rotate `col_sel` left ({col_sel[2:0], col_sel[3]}); 1110 → 1101 → 1011 → 0111 → 1110.
    - At a sample point with any row low: latch `col_idx` and the lowest-numbered low row into `cand_row`. Set `stable = 1`; go to DEBOUNCE. `col_sel` is frozen.
    - If DEBOUNCE_SCANS == 1, accept immediately, as in DEBOUNCE.
  - **DEBOUNCE**
    - At each sample point, if `row_s[cand_row]` is low, increment `stable`.
    - When `stable` reaches DEBOUNCE_SCANS: load `key_code`, pulse `key_valid`, go to HELD.
    - If `row_s[cand_row]` is high at a sample point: abandon the candidate, rotate the column, go to SCAN. No strobe is issued.
  - **HELD**
    - `key_held = 1`; column stays frozen.
    - Each sample point with `row_s[cand_row]` high increments `rel`. A low sample clears `rel`.
    - When `rel` reaches DEBOUNCE_SCANS: clear `key_held`, rotate the column, go to SCAN.
- Multiple keys:
  - Within one column, the lowest row wins.
  - Keys in other columns are invisible while frozen.
  - A second key in the same column as a held key produces no strobe.
- `key_code` holds its value until the next accepted press.
- Counter widths:
  - `dwell`: $clog2(SCAN_LIMIT+1).
  - `stable` and `rel`: 4 bits, saturating at DEBOUNCE_SCANS.

## Timing
- Reset values: `col_sel = 4'b1110`, `key_code = 0`, `key_valid = 0`, `key_held = 0`, FSM = SCAN, `dwell = 0`, `stable = rel = 0`, synchronizer flops = 4'hF.
- All outputs are registered. `key_valid` and `key_held` rise in the same cycle, one cycle after the accepting sample point.
- Press latency: up to 2 sync cycles, plus up to 4 dwells to reach the column, plus DEBOUNCE_SCANS dwells, plus 1 cycle.
- `col_sel` changes exactly one cycle after a sample point, never mid-dwell.
- Reset asserted mid-operation returns everything to reset values immediately, with no `key_valid` glitch. After reset is released, scanning restarts at column 0 with `dwell = 0`.
- A press shorter than DEBOUNCE_SCANS dwells never strobes. A release bounce shorter than DEBOUNCE_SCANS dwells never retriggers.

## Structure
- Add the following to the shared `const.sv`:
  - `KEYPAD_COL_RESET` (4'b1110).
  - `KEYPAD_NO_ROW` (4'hF).
  - State encodings `KEYPAD_ST_SCAN`, `KEYPAD_ST_DEBOUNCE`, `KEYPAD_ST_HELD`.
- Sub-module `sync2`: a parameterized-width two-flop synchronizer with asynchronous active-low reset to all-ones. It is reusable for other board inputs.

## Test plan
All scenarios use `SCAN_LIMIT = 3` (4-cycle dwell) and `DEBOUNCE_SCANS = 2`.
1. Idle with `row_n = 4'hF` for 32 cycles → `col_sel` steps 1110, 1101, 1011, 0111, 1110 every 4 cycles; `key_valid` stays 0.
2. Hold row 2 low only while col 1 is driven (steady press) → exactly one `key_valid` pulse with `key_code = 4'd9`; `key_held = 1`; `col_sel` frozen at 1101.
3. Row 0, col 3 pressed for exactly one dwell, then released → no `key_valid`; scanning resumes with the next column after 0111, i.e. 1110.
4. Rows 1 and 3 both low on col 0 → `key_code = 4'd4`; a single strobe.
5. While key 9 is held, toggle row 2 high for one dwell, then low again → no second strobe; `key_held` stays 1. A full release of 2 dwells → `key_held` falls and scanning resumes.
6. Assert `rst` during DEBOUNCE → next cycle `col_sel = 1110` and all outputs 0. After release, a steady press re-strobes normally.
